wfq_ingress_framer: RTL and testbench



---
 rtl/wfq_ingress_framer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_wfq_ingress_framer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wfq_ingress_framer.sv
// wfq_ingress_framer: store-and-forward ingress buffer that replays packets as WFQ_top writes.
// Define WFQ_INGRESS_STATS_EN to add saturating committed-packet and drop counters.
module wfq_ingress_framer #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned FLOW_W     = 13,
   parameter int unsigned LEN_W      = 9,
   parameter int unsigned BUF_AW     = 9,
   parameter int unsigned DESC_AW    = 4,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_sop,
   input  logic              s_eop,
   input  logic [DATA_W-1:0] s_data,
   input  logic [FLOW_W-1:0] s_flow_id,
   output logic              out_packet_arrival,
   output logic              out_data_arrival,
   output logic [LEN_W-1:0]  out_packet_length,
   output logic [FLOW_W-1:0] out_flow_id,
   output logic [DATA_W-1:0] out_packet_data,
   output logic              drop_pulse
`ifdef WFQ_INGRESS_STATS_EN
   ,
   output logic [31:0]       stat_pkt_count,
   output logic [31:0]       stat_drop_count
`endif
);

   localparam int unsigned BUF_DEPTH  = 1 << BUF_AW;
   localparam int unsigned DESC_DEPTH = 1 << DESC_AW;
   localparam int unsigned BPW        = BUF_AW + 1;
   localparam int unsigned DPW        = DESC_AW + 1;
   localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;
   localparam bit GAP_ONE = (GAP_CYCLES == 1);

   typedef struct packed {
      logic [FLOW_W-1:0] flow;
      logic [LEN_W-1:0]  len;
   } desc_t;

   typedef enum logic [1:0] {W_IDLE, W_PKT, W_DISC} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_EMIT, R_GAP} rd_state_e;

   // write side
   wr_state_e          wr_state_q, wr_state_d;
   logic [BPW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [BPW-1:0]     commit_ptr_q, commit_ptr_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [FLOW_W-1:0]  flow_q, flow_d;
   logic               hs_c, we_c, push_c, drop_c;
   logic [BUF_AW-1:0]  waddr_c;
   desc_t              push_desc_c;
   logic               s_ready_q, ready_d, drop_q;

   // storage
   logic [DATA_W-1:0]  mem_q [BUF_DEPTH];
   desc_t              desc_mem_q [DESC_DEPTH];
   logic [DPW-1:0]     dwp_q, dwp_d, drp_q, drp_d;
   logic [BPW-1:0]     used_d;
   logic [DPW-1:0]     dused_d;
   desc_t              head_c;
   logic [DATA_W-1:0]  rd_data_q;

   // read side
   rd_state_e          rd_state_q;
   logic [BPW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]   rem_q, cur_len_q;
   logic [FLOW_W-1:0]  cur_flow_q;
   logic [GAP_W-1:0]   gap_cnt_q;
   logic               first_q, rd_pend_q;
   logic               pop_c, rd_en_c;
   logic               out_pa_q, out_da_q;
   logic [LEN_W-1:0]   out_len_q;
   logic [FLOW_W-1:0]  out_flow_q;
   logic [DATA_W-1:0]  out_data_q;

   assign hs_c   = s_valid && s_ready_q;
   assign head_c = desc_mem_q[drp_q[DESC_AW-1:0]];
   assign pop_c  = (rd_state_q == R_IDLE) && (dwp_q != drp_q);
   assign rd_en_c = pop_c ||
                    ((rem_q != '0) &&
                     (((rd_state_q == R_GAP) && (gap_cnt_q == GAP_W'(1))) ||
                      (GAP_ONE && (rd_state_q == R_EMIT))));

   // Packet assembly: write, commit, and drop/rewind decisions for the accepted word
   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      cnt_d        = cnt_q;
      flow_d       = flow_q;
      we_c         = 1'b0;
      waddr_c      = wr_ptr_q[BUF_AW-1:0];
      push_c       = 1'b0;
      push_desc_c  = '0;
      drop_c       = 1'b0;
      if (hs_c) begin
         if ((wr_state_q != W_DISC) && s_sop) begin
            // a sop always restarts at the commit point, abandoning any partial packet
            drop_c   = (wr_state_q == W_PKT);
            we_c     = 1'b1;
            waddr_c  = commit_ptr_q[BUF_AW-1:0];
            wr_ptr_d = commit_ptr_q + BPW'(1);
            cnt_d    = LEN_W'(1);
            flow_d   = s_flow_id;
            if (s_eop) begin
               push_c       = 1'b1;
               push_desc_c  = {s_flow_id, LEN_W'(1)};
               commit_ptr_d = commit_ptr_q + BPW'(1);
               wr_state_d   = W_IDLE;
            end else begin
               wr_state_d = W_PKT;
            end
         end else begin
            case (wr_state_q)
               W_IDLE: drop_c = 1'b1;
               W_PKT: begin
                  if (cnt_q == LEN_MAX) begin
                     // this word would exceed the length field
                     drop_c     = 1'b1;
                     wr_ptr_d   = commit_ptr_q;
                     wr_state_d = s_eop ? W_IDLE : W_DISC;
                  end else begin
                     we_c     = 1'b1;
                     wr_ptr_d = wr_ptr_q + BPW'(1);
                     cnt_d    = cnt_q + LEN_W'(1);
                     if (s_eop) begin
                        push_c       = 1'b1;
                        push_desc_c  = {flow_q, cnt_q + LEN_W'(1)};
                        commit_ptr_d = wr_ptr_q + BPW'(1);
                        wr_state_d   = W_IDLE;
                     end
                  end
               end
               default: if (s_eop) wr_state_d = W_IDLE;
            endcase
         end
      end
   end

   // Next-cycle occupancy so s_ready can be registered
   always_comb begin
      rd_ptr_d = rd_ptr_q + BPW'(rd_en_c);
      drp_d    = drp_q + DPW'(pop_c);
      dwp_d    = dwp_q + DPW'(push_c);
      used_d   = wr_ptr_d - rd_ptr_d;
      dused_d  = dwp_d - drp_d;
      ready_d  = !used_d[BPW-1] && !dused_d[DPW-1];
   end

   // Write-side state, pointers and registered ready/drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q   <= W_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         cnt_q        <= '0;
         flow_q       <= '0;
         dwp_q        <= '0;
         s_ready_q    <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         wr_state_q   <= wr_state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         cnt_q        <= cnt_d;
         flow_q       <= flow_d;
         dwp_q        <= dwp_d;
         s_ready_q    <= ready_d;
         drop_q       <= drop_c;
      end
   end

   // Word buffer with one-cycle synchronous read, plus descriptor storage
   always_ff @(posedge clk) begin
      if (we_c) mem_q[waddr_c] <= s_data;
      if (rd_en_c) rd_data_q <= mem_q[rd_ptr_q[BUF_AW-1:0]];
      if (push_c) desc_mem_q[dwp_q[DESC_AW-1:0]] <= push_desc_c;
   end

   // Replay FSM: pop descriptor, then emit one word per EMIT separated by GAP_CYCLES idles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= R_IDLE;
         rd_ptr_q   <= '0;
         drp_q      <= '0;
         rem_q      <= '0;
         cur_len_q  <= '0;
         cur_flow_q <= '0;
         gap_cnt_q  <= '0;
         first_q    <= 1'b0;
         rd_pend_q  <= 1'b0;
         out_pa_q   <= 1'b0;
         out_da_q   <= 1'b0;
         out_len_q  <= '0;
         out_flow_q <= '0;
         out_data_q <= '0;
      end else begin
         out_pa_q <= 1'b0;
         out_da_q <= 1'b0;
         rd_ptr_q <= rd_ptr_d;
         drp_q    <= drp_d;
         if (rd_en_c) rd_pend_q <= 1'b1;
         if (rd_en_c && (rd_state_q != R_IDLE)) rem_q <= rem_q - LEN_W'(1);
         case (rd_state_q)
            R_IDLE: begin
               if (pop_c) begin
                  rd_state_q <= R_LOAD;
                  cur_flow_q <= head_c.flow;
                  cur_len_q  <= head_c.len;
                  rem_q      <= head_c.len - LEN_W'(1);
                  first_q    <= 1'b1;
               end
            end
            R_LOAD: begin
               rd_state_q <= R_EMIT;
               out_da_q   <= 1'b1;
               out_pa_q   <= first_q;
               out_len_q  <= cur_len_q;
               out_flow_q <= cur_flow_q;
               out_data_q <= rd_data_q;
               first_q    <= 1'b0;
               rd_pend_q  <= 1'b0;
            end
            R_EMIT: begin
               rd_state_q <= R_GAP;
               gap_cnt_q  <= GAP_W'(GAP_CYCLES - 1);
            end
            default: begin
               if (gap_cnt_q == '0) begin
                  if (rd_pend_q) begin
                     rd_state_q <= R_EMIT;
                     out_da_q   <= 1'b1;
                     out_pa_q   <= first_q;
                     out_len_q  <= cur_len_q;
                     out_flow_q <= cur_flow_q;
                     out_data_q <= rd_data_q;
                     first_q    <= 1'b0;
                     rd_pend_q  <= 1'b0;
                  end else begin
                     rd_state_q <= R_IDLE;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end
         endcase
      end
   end

   assign s_ready            = s_ready_q;
   assign drop_pulse         = drop_q;
   assign out_packet_arrival = out_pa_q;
   assign out_data_arrival   = out_da_q;
   assign out_packet_length  = out_len_q;
   assign out_flow_id        = out_flow_q;
   assign out_packet_data    = out_data_q;

`ifdef WFQ_INGRESS_STATS_EN
   logic [31:0] stat_pkt_q, stat_drop_q;

   // Saturating committed-packet and drop counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pkt_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         if (push_c && (stat_pkt_q != '1)) stat_pkt_q <= stat_pkt_q + 32'd1;
         if (drop_c && (stat_drop_q != '1)) stat_drop_q <= stat_drop_q + 32'd1;
      end
   end

   assign stat_pkt_count  = stat_pkt_q;
   assign stat_drop_count = stat_drop_q;
`endif

endmodule

// File: tb/tb_wfq_ingress_framer.sv
// tb_wfq_ingress_framer: directed checks of packet replay timing, drops and reset for wfq_ingress_framer.
module tb_wfq_ingress_framer;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned FLOW_W = 13;
   localparam int unsigned LEN_W  = 9;
   localparam int unsigned READY_LIMIT = 2000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic              s_sop = 1'b0;
   logic              s_eop = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic [FLOW_W-1:0] s_flow_id = '0;
   logic              out_packet_arrival;
   logic              out_data_arrival;
   logic [LEN_W-1:0]  out_packet_length;
   logic [FLOW_W-1:0] out_flow_id;
   logic [DATA_W-1:0] out_packet_data;
   logic              drop_pulse;
`ifdef WFQ_INGRESS_STATS_EN
   logic [31:0]       stat_pkt_count;
   logic [31:0]       stat_drop_count;
`endif

   wfq_ingress_framer dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_sop              (s_sop),
      .s_eop              (s_eop),
      .s_data             (s_data),
      .s_flow_id          (s_flow_id),
      .out_packet_arrival (out_packet_arrival),
      .out_data_arrival   (out_data_arrival),
      .out_packet_length  (out_packet_length),
      .out_flow_id        (out_flow_id),
      .out_packet_data    (out_packet_data),
      .drop_pulse         (drop_pulse)
`ifdef WFQ_INGRESS_STATS_EN
      ,
      .stat_pkt_count     (stat_pkt_count),
      .stat_drop_count    (stat_drop_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int                c;
      logic              pa;
      logic [LEN_W-1:0]  len;
      logic [FLOW_W-1:0] flow;
      logic [DATA_W-1:0] data;
   } ev_t;

   int   cyc = 0;
   int   drops = 0;
   int   nrdy = 0;
   ev_t  ev_q[$];
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (out_data_arrival)
         ev_q.push_back('{cyc, out_packet_arrival, out_packet_length, out_flow_id, out_packet_data});
      if (drop_pulse) drops = drops + 1;
      if (rst_n && !s_ready) nrdy = nrdy + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ev(input string t, input int idx, input int exp_c, input logic exp_pa,
                         input logic [LEN_W-1:0] exp_len, input logic [FLOW_W-1:0] exp_flow,
                         input logic [DATA_W-1:0] exp_data);
      if (idx < ev_q.size()) begin
         chk({t, "_cycle"}, 64'(ev_q[idx].c), 64'(exp_c));
         chk({t, "_pkt_arrival"}, 64'(ev_q[idx].pa), 64'(exp_pa));
         if (exp_pa) chk({t, "_length"}, 64'(ev_q[idx].len), 64'(exp_len));
         chk({t, "_flow"}, 64'(ev_q[idx].flow), 64'(exp_flow));
         chk({t, "_data"}, ev_q[idx].data, exp_data);
      end
   endtask

   // Present one word at a negedge and return at the negedge after it is accepted
   task automatic send_word(input logic sop, input logic eop, input logic [DATA_W-1:0] d,
                            input logic [FLOW_W-1:0] f);
      int guard = 0;
      s_valid   = 1'b1;
      s_sop     = sop;
      s_eop     = eop;
      s_data    = d;
      s_flow_id = f;
      while (!s_ready && guard < READY_LIMIT) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= READY_LIMIT) chk("ready_timeout", 64'(s_ready), 64'd1);
      @(negedge clk);
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
   endtask

   initial begin
      int e;
      int n0;
      int d0;
      int r0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_data_arrival", 64'(out_data_arrival), 64'd0);
      chk("rst_pkt_arrival", 64'(out_packet_arrival), 64'd0);
      chk("rst_drop", 64'(drop_pulse), 64'd0);
      chk("rst_length", 64'(out_packet_length), 64'd0);
      chk("rst_flow", 64'(out_flow_id), 64'd0);
      chk("rst_data", out_packet_data, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", 64'(s_ready), 64'd1);

      // 1: three-word packet
      n0 = ev_q.size(); d0 = drops;
      send_word(1'b1, 1'b0, 64'd0, 13'd0);
      send_word(1'b0, 1'b0, 64'd1, 13'd0);
      send_word(1'b0, 1'b1, 64'd2, 13'd0);
      e = cyc;
      repeat (30) @(negedge clk);
      chk("t1_events", 64'(ev_q.size() - n0), 64'd3);
      chk_ev("t1_w0", n0,     e + 2,  1'b1, 9'd3, 13'd0, 64'd0);
      chk_ev("t1_w1", n0 + 1, e + 7,  1'b0, 9'd3, 13'd0, 64'd1);
      chk_ev("t1_w2", n0 + 2, e + 12, 1'b0, 9'd3, 13'd0, 64'd2);
      chk("t1_drops", 64'(drops - d0), 64'd0);

      // 2: single-word packet
      n0 = ev_q.size();
      send_word(1'b1, 1'b1, 64'hAA, 13'd5);
      e = cyc;
      repeat (20) @(negedge clk);
      chk("t2_events", 64'(ev_q.size() - n0), 64'd1);
      chk_ev("t2_w0", n0, e + 2, 1'b1, 9'd1, 13'd5, 64'hAA);

      // 3: sop inside a packet abandons the partial one
      n0 = ev_q.size(); d0 = drops;
      send_word(1'b1, 1'b0, 64'h30, 13'd3);
      send_word(1'b1, 1'b0, 64'h70, 13'd7);
      send_word(1'b0, 1'b1, 64'h71, 13'd7);
      e = cyc;
      repeat (25) @(negedge clk);
      chk("t3_drops", 64'(drops - d0), 64'd1);
      chk("t3_events", 64'(ev_q.size() - n0), 64'd2);
      chk_ev("t3_w0", n0,     e + 2, 1'b1, 9'd2, 13'd7, 64'h70);
      chk_ev("t3_w1", n0 + 1, e + 7, 1'b0, 9'd2, 13'd7, 64'h71);

      // 4: twenty back-to-back single-word packets fill the descriptor FIFO
      n0 = ev_q.size(); r0 = nrdy; e = 0;
      for (int i = 0; i < 20; i++) begin
         send_word(1'b1, 1'b1, 64'(256 + i), 13'(i % 16));
         if (i == 0) e = cyc;
      end
      repeat (200) @(negedge clk);
      chk("t4_ready_dropped", 64'(nrdy > r0), 64'd1);
      chk("t4_events", 64'(ev_q.size() - n0), 64'd20);
      for (int i = 0; i < 20; i++)
         chk_ev($sformatf("t4_p%0d", i), n0 + i, e + 2 + 7 * i, 1'b1, 9'd1, 13'(i % 16), 64'(256 + i));

      // 5: 512-word packet is one drop; next packet lands at the restored pointer
      n0 = ev_q.size(); d0 = drops;
      send_word(1'b1, 1'b0, 64'd0, 13'd1);
      for (int i = 1; i < 511; i++) send_word(1'b0, 1'b0, 64'(i), 13'd1);
      send_word(1'b0, 1'b1, 64'd511, 13'd1);
      repeat (20) @(negedge clk);
      chk("t5_drops", 64'(drops - d0), 64'd1);
      chk("t5_no_output", 64'(ev_q.size() - n0), 64'd0);
      send_word(1'b1, 1'b0, 64'h5A0, 13'd9);
      send_word(1'b0, 1'b1, 64'h5A1, 13'd9);
      e = cyc;
      repeat (25) @(negedge clk);
      chk("t5_events", 64'(ev_q.size() - n0), 64'd2);
      chk_ev("t5_w0", n0,     e + 2, 1'b1, 9'd2, 13'd9, 64'h5A0);
      chk_ev("t5_w1", n0 + 1, e + 7, 1'b0, 9'd2, 13'd9, 64'h5A1);

      // 5b: stray word without sop, then a 514-word packet swallowed through eop
      n0 = ev_q.size(); d0 = drops;
      send_word(1'b0, 1'b0, 64'hDEAD, 13'd4);
      send_word(1'b1, 1'b0, 64'd0, 13'd2);
      for (int i = 1; i < 513; i++) send_word(1'b0, 1'b0, 64'(i), 13'd2);
      send_word(1'b0, 1'b1, 64'd513, 13'd2);
      repeat (20) @(negedge clk);
      chk("t5b_drops", 64'(drops - d0), 64'd2);
      send_word(1'b1, 1'b0, 64'hC0, 13'd12);
      send_word(1'b0, 1'b1, 64'hC1, 13'd12);
      e = cyc;
      repeat (25) @(negedge clk);
      chk("t5b_events", 64'(ev_q.size() - n0), 64'd2);
      chk_ev("t5b_w0", n0,     e + 2, 1'b1, 9'd2, 13'd12, 64'hC0);
      chk_ev("t5b_w1", n0 + 1, e + 7, 1'b0, 9'd2, 13'd12, 64'hC1);

      // 6: reset asserted during the gap of a three-word packet
      n0 = ev_q.size();
      send_word(1'b1, 1'b0, 64'h60, 13'd2);
      send_word(1'b0, 1'b0, 64'h61, 13'd2);
      send_word(1'b0, 1'b1, 64'h62, 13'd2);
      e = cyc;
      repeat (4) @(negedge clk);
      chk("t6_pre_events", 64'(ev_q.size() - n0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_data_arrival", 64'(out_data_arrival), 64'd0);
      chk("t6_rst_pkt_arrival", 64'(out_packet_arrival), 64'd0);
      chk("t6_rst_data", out_packet_data, 64'd0);
      chk("t6_rst_flow", 64'(out_flow_id), 64'd0);
      chk("t6_rst_length", 64'(out_packet_length), 64'd0);
      chk("t6_rst_ready", 64'(s_ready), 64'd0);
      n0 = ev_q.size();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_release_ready", 64'(s_ready), 64'd1);
      repeat (40) @(negedge clk);
      chk("t6_no_stale_output", 64'(ev_q.size() - n0), 64'd0);
      send_word(1'b1, 1'b0, 64'hB0, 13'd11);
      send_word(1'b0, 1'b1, 64'hB1, 13'd11);
      e = cyc;
      repeat (25) @(negedge clk);
      chk("t6_events", 64'(ev_q.size() - n0), 64'd2);
      chk_ev("t6_w0", n0,     e + 2, 1'b1, 9'd2, 13'd11, 64'hB0);
      chk_ev("t6_w1", n0 + 1, e + 7, 1'b0, 9'd2, 13'd11, 64'hB1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
